branch_predictor: RTL and testbench

- Dynamic branch predictor / branch target buffer (BTB) for the pipelined RISC-V core.
- Fetch side: combinational taken/target prediction for PCF.
- Execute side: takes the resolved outcome (derived from PCSrc, the PC-logic output), detects mispredictions, supplies the corrected next PC and trains the table.
- Sits between the fetch PC mux and the execute-stage PC logic; drives the BranchMispredicted input of that logic.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/sat_counter_2b.sv | 24 ++
 rtl/branch_predictor.sv | 143 ++++++++++++++
 tb/tb_branch_predictor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings and BTB entry layout for the RISC-V core front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    // Execute-stage PC-source class of the resolving instruction
    typedef enum logic [1:0] {
        PCS_NONE = 2'b00,
        PCS_BR   = 2'b01,
        PCS_JAL  = 2'b10,
        PCS_JALR = 2'b11
    } pcs_t;

    // Two-bit saturating direction counter states
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Tags are stored zero-extended to the widest possible tag (IDX_BITS=0),
    // so the entry layout does not depend on the table size.
    localparam int BTB_TAG_W = 30;

    // Payload of one BTB entry; valid bits live in a separate resettable
    // vector so that reset only has to clear one flop per entry.
    typedef struct packed {
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } btb_entry_t;

endpackage : riscv_pkg

// File: rtl/sat_counter_2b.sv
// Next-state of a 2-bit saturating taken/not-taken counter.
// Latency: combinational.
// Backpressure: none.
module sat_counter_2b
    import riscv_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    // Step toward ST on taken, toward SNT on not-taken, holding at the ends
    always_comb begin
        ctr_next = ctr;
        case (ctr)
            SNT:     ctr_next = taken ? WNT : SNT;
            WNT:     ctr_next = taken ? WT  : SNT;
            WT:      ctr_next = taken ? ST  : WNT;
            ST:      ctr_next = taken ? ST  : WT;
            default: ctr_next = ctr;
        endcase
    end

endmodule : sat_counter_2b

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch-side prediction, execute-side
// mispredict detection/recovery PC, training and statistics counters.
// Latency: prediction and mispredict combinational; table updates visible next cycle.
// Backpressure: none; stalled or flushed slots arrive with ValidE=0.
module branch_predictor
    import riscv_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        ValidE,
    input  logic [1:0]  PCSE,
    input  logic [31:0] PCE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    input  logic        ResolvedTakenE,
    input  logic [31:0] ResolvedTargetE,
    output logic        BranchMispredictE,
    output logic [31:0] CorrectPCE,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount
);

    localparam int ENTRIES = 1 << IDX_BITS;

    btb_entry_t          btb   [ENTRIES];
    logic [ENTRIES-1:0]  valid;

    logic [IDX_BITS-1:0]  idx_f, idx_e;
    logic [TAG_BITS-1:0]  tag_f_raw, tag_e_raw;
    logic [BTB_TAG_W-1:0] tag_f, tag_e;
    btb_entry_t           entry_f, entry_e, wr_entry;
    logic                 hit_f, hit_e, wr_en, wr_valid;
    ctr_t                 ctr_trained;
    logic                 unused_pc_bits;

    // Word-aligned PCs: the byte offset never takes part in index or tag
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    assign idx_f     = PCF[IDX_BITS+1:2];
    assign idx_e     = PCE[IDX_BITS+1:2];
    assign tag_f_raw = PCF[31:IDX_BITS+2];
    assign tag_e_raw = PCE[31:IDX_BITS+2];
    assign tag_f     = BTB_TAG_W'(tag_f_raw);
    assign tag_e     = BTB_TAG_W'(tag_e_raw);

    assign entry_f = btb[idx_f];
    assign entry_e = btb[idx_e];
    assign hit_f   = valid[idx_f] && (entry_f.tag == tag_f);
    assign hit_e   = valid[idx_e] && (entry_e.tag == tag_e);

    // Fetch lookup reads pre-edge contents only; no bypass from the update port
    always_comb begin
        PredTakenF  = hit_f && ((entry_f.ctr == WT) || (entry_f.ctr == ST));
        PredTargetF = PredTakenF ? entry_f.target : 32'd0;
    end

    // Mispredict on wrong direction, or on right direction with a wrong target
    always_comb begin
        BranchMispredictE = ValidE &&
                            ((PredTakenE != ResolvedTakenE) ||
                             (ResolvedTakenE && (PredTargetE != ResolvedTargetE)));
        CorrectPCE        = ResolvedTakenE ? ResolvedTargetE : (PCE + 32'd4);
    end

    sat_counter_2b u_sat_counter (
        .ctr      (entry_e.ctr),
        .taken    (ResolvedTakenE),
        .ctr_next (ctr_trained)
    );

    // Training decision: what, if anything, gets written at PCE's slot
    always_comb begin
        wr_en    = 1'b0;
        wr_valid = 1'b1;
        wr_entry = entry_e;
        if (ValidE) begin
            case (PCSE)
                PCS_BR: begin
                    if (hit_e) begin
                        wr_en        = 1'b1;
                        wr_entry.ctr = ctr_trained;
                        if (ResolvedTakenE) begin
                            wr_entry.target = ResolvedTargetE;
                        end
                    end else if (ResolvedTakenE) begin
                        // First taken sighting: allocate weakly taken
                        wr_en           = 1'b1;
                        wr_entry.tag    = tag_e;
                        wr_entry.target = ResolvedTargetE;
                        wr_entry.ctr    = WT;
                    end
                end
                PCS_JAL: begin
                    wr_en           = 1'b1;
                    wr_entry.tag    = tag_e;
                    wr_entry.target = ResolvedTargetE;
                    wr_entry.ctr    = ST;
                end
                default: begin
                    // jalr targets are register-dependent and non-control
                    // hits are stale: drop any matching entry
                    if (hit_e) begin
                        wr_en    = 1'b1;
                        wr_valid = 1'b0;
                    end
                end
            endcase
        end
    end

    // Entry payload: no reset needed, contents are ignored until valid is set
    always_ff @(posedge CLK) begin
        if (wr_en && wr_valid) begin
            btb[idx_e] <= wr_entry;
        end
    end

    // Valid bits and statistics; reset wins over a concurrent update
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid           <= '0;
            BranchCount     <= 32'd0;
            MispredictCount <= 32'd0;
        end else begin
            if (wr_en) begin
                valid[idx_e] <= wr_valid;
            end
            if (ValidE && (PCSE != PCS_NONE)) begin
                BranchCount <= BranchCount + 32'd1;
            end
            if (BranchMispredictE) begin
                MispredictCount <= MispredictCount + 32'd1;
            end
        end
    end

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Latency: checks combinational outputs #2 after an edge, state after the next edge.
// Backpressure: n/a.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        ValidE;
    logic [1:0]  PCSE;
    logic [31:0] PCE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        ResolvedTakenE;
    logic [31:0] ResolvedTargetE;
    logic        BranchMispredictE;
    logic [31:0] CorrectPCE;
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .PCF               (PCF),
        .PredTakenF        (PredTakenF),
        .PredTargetF       (PredTargetF),
        .ValidE            (ValidE),
        .PCSE              (PCSE),
        .PCE               (PCE),
        .PredTakenE        (PredTakenE),
        .PredTargetE       (PredTargetE),
        .ResolvedTakenE    (ResolvedTakenE),
        .ResolvedTargetE   (ResolvedTargetE),
        .BranchMispredictE (BranchMispredictE),
        .CorrectPCE        (CorrectPCE),
        .BranchCount       (BranchCount),
        .MispredictCount   (MispredictCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_e(input logic v, input logic [1:0] pcs, input logic [31:0] pc,
                           input logic pt, input logic [31:0] ptgt,
                           input logic rt, input logic [31:0] rtgt);
        ValidE          = v;
        PCSE            = pcs;
        PCE             = pc;
        PredTakenE      = pt;
        PredTargetE     = ptgt;
        ResolvedTakenE  = rt;
        ResolvedTargetE = rtgt;
        #1;
    endtask

    task automatic idle_e();
        drive_e(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] pc,
                            input logic taken, input logic [31:0] tgt);
        PCF = pc;
        #1;
        chk({tag, "_taken"}, 32'(PredTakenF), 32'(taken));
        chk({tag, "_tgt"}, PredTargetF, tgt);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] br, input logic [31:0] mp);
        chk({tag, "_brcnt"}, BranchCount, br);
        chk({tag, "_mpcnt"}, MispredictCount, mp);
    endtask

    initial begin
        RESET = 1'b1;
        PCF   = 32'h100;
        idle_e();
        tick();
        tick();
        RESET = 1'b0;

        // Reset state
        chk_pred("rst", 32'h100, 1'b0, 32'h0);
        chk_cnt("rst", 32'd0, 32'd0);

        // First taken branch at 0x100: mispredict, allocate WT
        drive_e(1'b1, 2'b01, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("alloc_mp", 32'(BranchMispredictE), 32'd1);
        chk("alloc_cpc", CorrectPCE, 32'h80);
        chk_pred("nobypass", 32'h100, 1'b0, 32'h0);
        tick();
        idle_e();
        chk_pred("alloc", 32'h100, 1'b1, 32'h80);
        chk_cnt("alloc", 32'd1, 32'd1);

        // Taken twice, correctly predicted: WT -> ST -> ST
        drive_e(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("tk1_mp", 32'(BranchMispredictE), 32'd0);
        tick();
        drive_e(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("tk2_mp", 32'(BranchMispredictE), 32'd0);
        tick();

        // Wrong-target probe: right direction, different target (not clocked in)
        drive_e(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 1'b1, 32'h90);
        chk("tgt_mp", 32'(BranchMispredictE), 32'd1);
        chk("tgt_cpc", CorrectPCE, 32'h90);
        idle_e();

        // Not taken once: ST -> WT, still predicted taken
        drive_e(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
        chk("nt1_mp", 32'(BranchMispredictE), 32'd1);
        chk("nt1_cpc", CorrectPCE, 32'h104);
        tick();
        idle_e();
        chk_pred("nt1", 32'h100, 1'b1, 32'h80);

        // Not taken again: WT -> WNT, no longer predicted
        drive_e(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
        chk("nt2_mp", 32'(BranchMispredictE), 32'd1);
        tick();
        idle_e();
        chk_pred("nt2", 32'h100, 1'b0, 32'h0);
        chk_cnt("nt2", 32'd5, 32'd3);

        // Retrain taken: WNT -> WT, predicted again
        drive_e(1'b1, 2'b01, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        idle_e();
        chk_pred("retrain", 32'h100, 1'b1, 32'h80);

        // jal at 0x140 aliases index 0 and evicts 0x100
        drive_e(1'b1, 2'b10, 32'h140, 1'b0, 32'h0, 1'b1, 32'h400);
        chk("jal_mp", 32'(BranchMispredictE), 32'd1);
        tick();
        idle_e();
        chk_pred("alias_old", 32'h100, 1'b0, 32'h0);
        chk_pred("alias_new", 32'h140, 1'b1, 32'h400);
        chk_cnt("alias", 32'd7, 32'd5);

        // jalr at 0x200 three times: never allocated, always mispredicts
        for (int i = 0; i < 3; i++) begin
            drive_e(1'b1, 2'b11, 32'h200, 1'b0, 32'h0, 1'b1, 32'h300);
            chk($sformatf("jalr%0d_mp", i), 32'(BranchMispredictE), 32'd1);
            chk($sformatf("jalr%0d_cpc", i), CorrectPCE, 32'h300);
            tick();
            idle_e();
            chk_pred($sformatf("jalr%0d", i), 32'h200, 1'b0, 32'h0);
        end
        chk_cnt("jalr", 32'd10, 32'd8);

        // Non-control instruction hitting 0x140 invalidates the stale entry
        drive_e(1'b1, 2'b00, 32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("none_mp", 32'(BranchMispredictE), 32'd0);
        tick();
        idle_e();
        chk_pred("none_inval", 32'h140, 1'b0, 32'h0);
        chk_cnt("none", 32'd10, 32'd8);

        // ValidE=0 with taken-branch inputs: nothing happens
        drive_e(1'b0, 2'b01, 32'h180, 1'b0, 32'h0, 1'b1, 32'h500);
        chk("inv_mp", 32'(BranchMispredictE), 32'd0);
        tick();
        idle_e();
        chk_pred("inv", 32'h180, 1'b0, 32'h0);
        chk_cnt("inv", 32'd10, 32'd8);

        // Populate 0x1C0 so reset has a live entry to clear
        drive_e(1'b1, 2'b10, 32'h1C0, 1'b0, 32'h0, 1'b1, 32'h600);
        tick();
        idle_e();
        chk_pred("pre_rst", 32'h1C0, 1'b1, 32'h600);
        chk_cnt("pre_rst", 32'd11, 32'd9);

        // Reset with a concurrent valid jal update: reset wins
        RESET = 1'b1;
        drive_e(1'b1, 2'b10, 32'h180, 1'b0, 32'h0, 1'b1, 32'h500);
        chk("rst_mp_ungated", 32'(BranchMispredictE), 32'd1);
        tick();
        RESET = 1'b0;
        idle_e();
        chk_pred("post_rst_upd", 32'h180, 1'b0, 32'h0);
        chk_pred("post_rst_old", 32'h1C0, 1'b0, 32'h0);
        chk_cnt("post_rst", 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_branch_predictor
